// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Read tag travelling alongside the memory read: who asked, and whether anyone did.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/mem_arb_if.sv
// Request/response bundle for both requesters plus the memory-side ports.
// Latency: n/a (wires only).
// Backpressure: rK_ready is the only request backpressure; responses have none.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          r0_valid;
  logic          r0_ready;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_valid;
  logic          r1_ready;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_wra;
  logic [DW-1:0] mem_wrd;
  logic [AW-1:0] mem_rda;
  logic [DW-1:0] mem_rdd;

  // Requester / memory side of the arbiter
  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_we, mem_wra, mem_wrd, mem_rda,
    output mem_rdd
  );

  // Arbiter side
  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_we, mem_wra, mem_wrd, mem_rda,
    input  mem_rdd
  );

endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// Two-stage read-tag shift register and read-data demux back to the requester.
// Latency: response registered 2 clocks after the tag is presented.
// Backpressure: none; responses are one-cycle pulses that must be taken.
module mem_arb_rsp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  tag_t          tag_i,
  input  logic [DW-1:0] rdd_i,
  output logic          rvalid0_o,
  output logic [DW-1:0] rdata0_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata1_o
);

  tag_t          s1_q, s2_q;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic          hit0, hit1;

  assign hit0 = s2_q.valid && (s2_q.id == REQ0);
  assign hit1 = s2_q.valid && (s2_q.id == REQ1);

  // Shift tags; stage 2 lines up with the memory's registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      s1_q  <= tag_i;
      s2_q  <= s1_q;
      rv0_q <= hit0;
      rv1_q <= hit1;
      if (hit0) rd0_q <= rdd_i;
      if (hit1) rd1_q <= rdd_i;
    end
  end

  assign rvalid0_o = rv0_q;
  assign rdata0_o  = rd0_q;
  assign rvalid1_o = rv1_q;
  assign rdata1_o  = rd1_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one write port and one read port of a sync memory between two requesters.
// Latency: mem_* registered at acceptance; read data returns 2 clocks after acceptance.
// Backpressure: combinational rK_ready; round-robin only on same-type contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  mem_arb_if.slave      bus,
  output logic [CW-1:0] conflicts
);

  logic          prio_q, prio_d;
  logic [CW-1:0] conf_q, conf_d;
  logic          gnt0, gnt1, contest;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_wra_q, mem_wra_d;
  logic [DW-1:0] mem_wrd_q, mem_wrd_d;
  logic [AW-1:0] mem_rda_q, mem_rda_d;
  tag_t          tag_d;

  // Grant decision: mixed read/write pairs both go; same-type pairs follow prio.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    contest = 1'b0;
    if (en && !reset) begin
      if (bus.r0_valid && bus.r1_valid && (bus.r0_we == bus.r1_we)) begin
        contest = 1'b1;
        gnt0    = (prio_q == REQ0);
        gnt1    = (prio_q == REQ1);
      end else begin
        gnt0 = bus.r0_valid;
        gnt1 = bus.r1_valid;
      end
    end
  end

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;

  // Steer granted requests onto the memory ports; update prio and conflict count.
  always_comb begin
    prio_d    = prio_q;
    conf_d    = conf_q;
    mem_we_d  = 1'b0;
    mem_wra_d = mem_wra_q;
    mem_wrd_d = mem_wrd_q;
    mem_rda_d = mem_rda_q;
    tag_d     = '0;
    if (contest) begin
      prio_d = ~prio_q;
      if (conf_q != '1) conf_d = conf_q + 1'b1;
    end
    if (gnt0 && bus.r0_we) begin
      mem_we_d  = 1'b1;
      mem_wra_d = bus.r0_addr;
      mem_wrd_d = bus.r0_wdata;
    end else if (gnt1 && bus.r1_we) begin
      mem_we_d  = 1'b1;
      mem_wra_d = bus.r1_addr;
      mem_wrd_d = bus.r1_wdata;
    end
    if (gnt0 && !bus.r0_we) begin
      mem_rda_d = bus.r0_addr;
      tag_d     = '{valid: 1'b1, id: REQ0};
    end else if (gnt1 && !bus.r1_we) begin
      mem_rda_d = bus.r1_addr;
      tag_d     = '{valid: 1'b1, id: REQ1};
    end
  end

  // State and memory-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q    <= REQ0;
      conf_q    <= '0;
      mem_we_q  <= 1'b0;
      mem_wra_q <= '0;
      mem_wrd_q <= '0;
      mem_rda_q <= '0;
    end else begin
      prio_q    <= prio_d;
      conf_q    <= conf_d;
      mem_we_q  <= mem_we_d;
      mem_wra_q <= mem_wra_d;
      mem_wrd_q <= mem_wrd_d;
      mem_rda_q <= mem_rda_d;
    end
  end

  assign bus.mem_we  = mem_we_q;
  assign bus.mem_wra = mem_wra_q;
  assign bus.mem_wrd = mem_wrd_q;
  assign bus.mem_rda = mem_rda_q;
  assign conflicts   = conf_q;

  mem_arb_rsp_pipe #(.DW(DW)) u_rsp_pipe (
    .clock     (clock),
    .reset     (reset),
    .tag_i     (tag_d),
    .rdd_i     (bus.mem_rdd),
    .rvalid0_o (bus.r0_rvalid),
    .rdata0_o  (bus.r0_rdata),
    .rvalid1_o (bus.r1_rvalid),
    .rdata1_o  (bus.r1_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of grant vectors, directed corner sequences, random traffic.
// Latency: reference model expects responses 2 clocks after acceptance.
// Backpressure: requesters hold requests until the model says they were accepted.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [15:0] conflicts;
  logic [1:0]  conflicts_sat;

  mem_arb_if #(.AW(8), .DW(8)) bus ();
  mem_arb_if #(.AW(8), .DW(8)) bus2 ();

  mem_arbiter #(.AW(8), .DW(8), .CW(16)) dut (
    .clock(clock), .reset(reset), .en(en), .bus(bus), .conflicts(conflicts)
  );

  mem_arbiter #(.AW(8), .DW(8), .CW(2)) dut_sat (
    .clock(clock), .reset(reset), .en(en), .bus(bus2), .conflicts(conflicts_sat)
  );

  // Narrow-counter instance sees the same request traffic.
  assign bus2.r0_valid = bus.r0_valid;
  assign bus2.r0_we    = bus.r0_we;
  assign bus2.r0_addr  = bus.r0_addr;
  assign bus2.r0_wdata = bus.r0_wdata;
  assign bus2.r1_valid = bus.r1_valid;
  assign bus2.r1_we    = bus.r1_we;
  assign bus2.r1_addr  = bus.r1_addr;
  assign bus2.r1_wdata = bus.r1_wdata;
  assign bus2.mem_rdd  = 8'h00;

  always #5 clock = ~clock;

  // Memory: 256x8, read registered (read-before-write on same address).
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_wra] <= bus.mem_wrd;
    bus.mem_rdd <= mem[bus.mem_rda];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } rsp_t;

  rsp_t       rspq[$];
  rsp_t       rsp;
  logic [7:0] model_mem [256] = '{default: 8'h00};
  int         prio_m = 0, confl_m = 0, confl2_m = 0;
  logic       acc [2];
  logic       mv [2], mwe [2];
  logic [7:0] ma [2], md [2];
  logic       m_cont;
  logic       exp_rv [2];
  logic [7:0] exp_rd [2];
  logic       exp_we;
  logic [7:0] exp_wra, exp_wrd, exp_rda;

  initial begin
    acc[0] = 0; acc[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0;
    exp_rd[0] = 0; exp_rd[1] = 0; exp_we = 0;
    exp_wra = 0; exp_wrd = 0; exp_rda = 0;
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
    mv[0] = bus.r0_valid; mwe[0] = bus.r0_we; ma[0] = bus.r0_addr; md[0] = bus.r0_wdata;
    mv[1] = bus.r1_valid; mwe[1] = bus.r1_we; ma[1] = bus.r1_addr; md[1] = bus.r1_wdata;
    acc[0] = 0; acc[1] = 0;
    m_cont = 0;
    if (!reset && en) begin
      if (mv[0] && mv[1] && mwe[0] == mwe[1]) begin
        m_cont = 1;
        acc[prio_m] = 1;
      end else begin
        acc[0] = mv[0];
        acc[1] = mv[1];
      end
    end
    if (chk_on) begin
      chk("r0_ready", bus.r0_ready, acc[0]);
      chk("r1_ready", bus.r1_ready, acc[1]);
    end
    exp_rv[0] = 0; exp_rv[1] = 0; exp_we = 0;
    if (reset) begin
      prio_m = 0; confl_m = 0; confl2_m = 0;
      rspq.delete();
      exp_rd[0] = 0; exp_rd[1] = 0;
      exp_wra = 0; exp_wrd = 0; exp_rda = 0;
    end else begin
      if (m_cont) begin
        prio_m = 1 - prio_m;
        if (confl_m < 65535) confl_m++;
        if (confl2_m < 3) confl2_m++;
      end
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        rsp = rspq.pop_front();
        exp_rv[rsp.id] = 1;
        exp_rd[rsp.id] = rsp.data;
      end
      for (int k = 0; k < 2; k++)
        if (acc[k] && !mwe[k]) begin
          rspq.push_back('{k, model_mem[ma[k]], cyc + 2});
          exp_rda = ma[k];
        end
      for (int k = 0; k < 2; k++)
        if (acc[k] && mwe[k]) begin
          exp_we  = 1;
          exp_wra = ma[k];
          exp_wrd = md[k];
          model_mem[ma[k]] = md[k];
        end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("r0_rvalid", bus.r0_rvalid, exp_rv[0]);
      chk("r1_rvalid", bus.r1_rvalid, exp_rv[1]);
      chk("r0_rdata", bus.r0_rdata, exp_rd[0]);
      chk("r1_rdata", bus.r1_rdata, exp_rd[1]);
      chk("mem_we", bus.mem_we, exp_we);
      chk("mem_wra", bus.mem_wra, exp_wra);
      chk("mem_wrd", bus.mem_wrd, exp_wrd);
      chk("mem_rda", bus.mem_rda, exp_rda);
      chk("conflicts", conflicts, confl_m);
      chk("conflicts_sat", conflicts_sat, confl2_m);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input int k, input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    if (k == 0) begin
      bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic idle();
    req(0, 0, 0, 8'h00, 8'h00);
    req(1, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  typedef struct {
    logic en, v0, we0, v1, we1, rdy0, rdy1;
    int   conf;
  } vec_t;

  vec_t vt [10];
  int   sat_exp [5];
  logic pend [2];

  initial begin
    vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 1, 0, 0, 0, 1, 0, 0};
    vt[2] = '{1, 0, 0, 1, 1, 0, 1, 0};
    vt[3] = '{1, 1, 1, 1, 0, 1, 1, 0};
    vt[4] = '{1, 1, 0, 1, 0, 1, 0, 1};
    vt[5] = '{1, 1, 1, 1, 1, 0, 1, 2};
    vt[6] = '{0, 1, 0, 1, 0, 0, 0, 2};
    vt[7] = '{1, 1, 1, 1, 1, 1, 0, 3};
    vt[8] = '{1, 1, 0, 1, 1, 1, 1, 3};
    vt[9] = '{1, 0 + 1, 0, 1, 0, 0, 1, 4};
    sat_exp = '{1, 2, 3, 3, 3};

    idle();
    reset = 1;
    @(negedge clock);
    @(negedge clock);
    chk_on = 1;
    reset = 0;
    en = 1;

    // Reset then idle: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_rvalid0", bus.r0_rvalid, 0);
      chk("idle_rvalid1", bus.r1_rvalid, 0);
      chk("idle_mem_we", bus.mem_we, 0);
    end
    chk("idle_conflicts", conflicts, 0);
    chk("idle_rdata0", bus.r0_rdata, 0);

    // Grant-rule table, starting from prio = requester 0.
    for (int i = 0; i < 10; i++) begin
      en = vt[i].en;
      req(0, vt[i].v0, vt[i].we0, 8'h40, 8'(i));
      req(1, vt[i].v1, vt[i].we1, 8'h48, 8'(i + 8'h80));
      #1;
      chk("tbl_rdy0", bus.r0_ready, vt[i].rdy0);
      chk("tbl_rdy1", bus.r1_ready, vt[i].rdy1);
      @(negedge clock);
      chk("tbl_conf", conflicts, vt[i].conf);
    end
    en = 1;
    idle();
    repeat (3) @(negedge clock);

    // r0 write A5 @10, read it back next cycle.
    req(0, 1, 1, 8'h10, 8'hA5); #1 chk("wr_rdy", bus.r0_ready, 1);
    @(negedge clock);
    req(0, 1, 0, 8'h10, 8'h00); #1 chk("rd_rdy", bus.r0_ready, 1);
    @(negedge clock); idle(); chk("wrrd_early1", bus.r0_rvalid, 0);
    @(negedge clock);         chk("wrrd_early2", bus.r0_rvalid, 0);
    @(negedge clock);
    chk("wrrd_rvalid", bus.r0_rvalid, 1);
    chk("wrrd_rdata", bus.r0_rdata, 8'hA5);
    chk("wrrd_r1_quiet", bus.r1_rvalid, 0);
    @(negedge clock);         chk("wrrd_pulse_end", bus.r0_rvalid, 0);

    // Same-cycle write/read to 0x20 returns old data; read one cycle later returns new.
    req(0, 1, 1, 8'h20, 8'h3C); req(1, 1, 0, 8'h20, 8'h00);
    #1 chk("same_rdy0", bus.r0_ready, 1); chk("same_rdy1", bus.r1_ready, 1);
    @(negedge clock); idle(); req(1, 1, 0, 8'h20, 8'h00);
    #1 chk("follow_rdy1", bus.r1_ready, 1);
    @(negedge clock); idle();
    @(negedge clock);
    chk("same_rvalid", bus.r1_rvalid, 1);
    chk("same_old_data", bus.r1_rdata, 8'h00);
    @(negedge clock);
    chk("follow_rvalid", bus.r1_rvalid, 1);
    chk("follow_new_data", bus.r1_rdata, 8'h3C);
    @(negedge clock);

    // Continuous contending reads: alternate grants, ordered responses.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        req(0, 1, 0, 8'h10, 8'h00);
        req(1, 1, 0, 8'h20, 8'h00);
        #1;
        chk("rr_gnt0", bus.r0_ready, (i % 2) == 0);
        chk("rr_gnt1", bus.r1_ready, (i % 2) == 1);
      end else begin
        idle();
        #1;
      end
      if (i >= 3 && i < 9) begin
        chk("rr_rv0", bus.r0_rvalid, ((i - 3) % 2) == 0);
        chk("rr_rv1", bus.r1_rvalid, ((i - 3) % 2) == 1);
        if (((i - 3) % 2) == 0) chk("rr_rd0", bus.r0_rdata, 8'hA5);
        else                    chk("rr_rd1", bus.r1_rdata, 8'h3C);
      end else begin
        chk("rr_rv0_quiet", bus.r0_rvalid, 0);
        chk("rr_rv1_quiet", bus.r1_rvalid, 0);
      end
      if (i == 6) chk("rr_conflicts", conflicts, 6);
      @(negedge clock);
    end

    // Reads in flight when reset hits: no responses afterwards.
    req(0, 1, 0, 8'h10, 8'h00); #1 chk("mid_rdy0", bus.r0_ready, 1);
    @(negedge clock); idle(); req(1, 1, 0, 8'h20, 8'h00); #1 chk("mid_rdy1", bus.r1_ready, 1);
    @(negedge clock); reset = 1; req(0, 1, 0, 8'h10, 8'h00);
    #1 chk("rst_rdy0", bus.r0_ready, 0); chk("rst_rdy1", bus.r1_ready, 0);
    @(negedge clock); idle();
    chk("rst_rv0", bus.r0_rvalid, 0);
    chk("rst_rv1", bus.r1_rvalid, 0);
    chk("rst_rd0", bus.r0_rdata, 0);
    chk("rst_rd1", bus.r1_rdata, 0);
    chk("rst_rda", bus.mem_rda, 0);
    chk("rst_conf", conflicts, 0);
    @(negedge clock); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_rv0", bus.r0_rvalid, 0);
      chk("post_rst_rv1", bus.r1_rvalid, 0);
    end

    // Saturating 2-bit counter, then en low holds everything.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(0, 1, 1, 8'h50, 8'(i));
      req(1, 1, 1, 8'h51, 8'(i));
      @(negedge clock);
      chk("sat_conf", conflicts_sat, sat_exp[i]);
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("en0_rdy0", bus.r0_ready, 0); chk("en0_rdy1", bus.r1_ready, 0);
      @(negedge clock);
      chk("en0_conf_sat", conflicts_sat, 3);
      chk("en0_conf", conflicts, 5);
    end
    en = 1;
    idle();
    repeat (3) @(negedge clock);

    // Random traffic against the model.
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] || acc[k]) begin
          pend[k] = ($urandom_range(0, 9) < 6);
          req(k, pend[k], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
      en    = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    reset = 0;
    en = 1;
    idle();
    repeat (4) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
